fnd_scan_ctrl: RTL and testbench
================================

FND_SCAN_CTRL -- requirements
Module: fnd_scan_ctrl

Purpose: 4-digit time-multiplexed scan stage directly upstream of seg_decoder. It drives hex_value into the decoder and generates the common-anode digit enables (com), replacing the static com = 4'b0000 tie-off.

Interface
REQ-001 Parameter SCAN_DIV, default 100000, meaning clk cycles each digit is lit (SHOW phase); legal range is at least 2.
REQ-002 Parameter GAP_CYC, default 1000, meaning clk cycles all digits are off between digits (anti-ghosting); legal range is at least 1.
REQ-003 clk  input  1  sole clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 value  input  16  four hex nibbles; value[3:0] is digit 0 (rightmost), value[15:12] is digit 3.
REQ-006 dp_in  input  4  decimal-point request per digit, bit n for digit n, active-high; captured with value.
REQ-007 load  input  1  single-cycle strobe that captures value and dp_in into the pending buffer.
REQ-008 blank_lz  input  1  level; when 1, leading-zero digits are suppressed.
REQ-009 hex_value  output  4  nibble for the currently lit digit, routed to seg_decoder.hex_value.
REQ-010 dp  output  1  decimal point for the lit digit, active-high.
REQ-011 com  output  4  digit enables, active-low, com[n] selects digit n.
REQ-012 frame_start  output  1  one-cycle pulse on entry to digit-0 SHOW.

Function
REQ-013 All outputs SHALL be registered; there are no combinational input-to-output paths.
REQ-014 FSM states: SHOW and GAP; there is a 2-bit digit index idx and a phase counter cnt.
REQ-015 SHOW SHALL last exactly SCAN_DIV cycles; during SHOW com is ~(4'b0001<<idx), subject to REQ-019.
REQ-016 GAP SHALL last exactly GAP_CYC cycles; during GAP com is 4'b1111 and dp is 0.
REQ-017 The state SHALL step SHOW->GAP with idx held, then GAP->SHOW with idx+1 (modulo 4; 3 wraps to 0).
REQ-018 hex_value SHALL equal shown[4*idx+3:4*idx] and dp SHALL equal shown_dp[idx] throughout SHOW; during GAP hex_value holds its last value.
REQ-019 Leading-zero suppression, when blank_lz=1, operates on the shown nibbles:
  - digit 3 is blanked if nibble3==0;
  - digit 2 is blanked if nibbles 3 and 2 are both 0;
  - digit 1 is blanked if nibbles 3, 2 and 1 are all 0;
  - digit 0 is never blanked.
  A blanked digit keeps com=4'b1111 and dp=0 for its whole SHOW, with timing unchanged. A digit with shown_dp set is never blanked.
REQ-020 load=1 SHALL write pend<=value, pend_dp<=dp_in and set pend_valid; a later load overwrites the buffer (last value wins).
REQ-021 On the GAP(idx=3)->SHOW(idx=0) transition, if pend_valid=1 then shown<=pend, shown_dp<=pend_dp and pend_valid is cleared. The display therefore never tears within a frame.
REQ-022 If load=1 on the REQ-021 transition cycle, the new inputs go directly into shown/shown_dp and pend_valid is cleared.
REQ-023 frame_start SHALL be 1 for exactly the first cycle of each digit-0 SHOW.
REQ-024 Frame period SHALL be 4*(SCAN_DIV+GAP_CYC) cycles.

Reset
REQ-025 Reset SHALL set:
  - state=GAP, idx=3, cnt=0;
  - shown=0, shown_dp=0, pend=0, pend_dp=0, pend_valid=0;
  - com=4'b1111, hex_value=0, dp=0, frame_start=0.
REQ-026 Reset asserted mid-frame SHALL abort the current frame. After release: GAP_CYC cycles with com=4'b1111, then digit-0 SHOW with frame_start=1.
REQ-027 load asserted together with reset SHALL be ignored.

Verification (SCAN_DIV=4, GAP_CYC=2)
REQ-028 Release reset, no load -> 2 cycles com=1111, frame_start pulse, 4 cycles com=1110 hex=0, then 2 cycles com=1111, 4 cycles com=1101; frame period is 24 cycles.
REQ-029 load value=16'h12AF, dp_in=4'b0100 mid-frame -> the current frame still shows 0s. The next frame shows digit0=F, digit1=A, digit2=2 with dp=1, digit3=1.
REQ-030 blank_lz=1, value=16'h0050 -> digits 3 and 2 have com=1111 for their full SHOW; digit1=5 and digit0=0 are lit. With value=16'h0000, only digit 0 is lit.
REQ-031 Two loads in one frame (16'h1111, then 16'h2222) -> the next frame shows 2222; 1111 is never displayed.
REQ-032 load 16'hBEEF on the exact GAP(3)->SHOW(0) cycle -> that same digit-0 SHOW has hex=F, and digit 1 shows E.
REQ-033 reset during digit-2 SHOW -> com=1111 on the next cycle, shown=0, and the REQ-028 sequence repeats.

Source files
------------

// File: rtl/fnd_scan_ctrl_if.sv
// Bus between the display-value producer and the 4-digit scan controller.
// The master side supplies the value to show; the slave side drives the
// nibble for seg_decoder and the active-low common-anode digit enables.
interface fnd_scan_ctrl_if;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        load;
  logic        blank_lz;
  logic [3:0]  hex_value;
  logic        dp;
  logic [3:0]  com;
  logic        frame_start;

  modport master (
    output value, dp_in, load, blank_lz,
    input  hex_value, dp, com, frame_start
  );

  modport slave (
    input  value, dp_in, load, blank_lz,
    output hex_value, dp, com, frame_start
  );
endinterface

// File: rtl/fnd_scan_ctrl.sv
// Four-digit time-multiplexed scan stage that feeds seg_decoder.
// Each digit is lit for SCAN_DIV cycles and then all digits go dark for
// GAP_CYC cycles, which suppresses ghosting. A new value is first held in a
// pending buffer and is only copied into the displayed copy at the frame
// boundary (GAP of digit 3 into SHOW of digit 0), so a frame never tears.
// All outputs come from registers and are computed from next-state values,
// so each output register lines up with the state it describes.
module fnd_scan_ctrl #(
  parameter int SCAN_DIV = 100000,
  parameter int GAP_CYC  = 1000
) (
  input  logic           clk,
  input  logic           reset,
  fnd_scan_ctrl_if.slave bus
);

  localparam int MAXC = (SCAN_DIV > GAP_CYC) ? SCAN_DIV : GAP_CYC;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [CW-1:0] SHOW_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYC - 1);

  localparam logic [0:0] ST_SHOW = 1'b0;
  localparam logic [0:0] ST_GAP  = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [15:0] shown_q, shown_d;
  logic [3:0]  shown_dp_q, shown_dp_d;
  logic [15:0] pend_q, pend_d;
  logic [3:0]  pend_dp_q, pend_dp_d;
  logic        pend_valid_q, pend_valid_d;

  logic [3:0]  com_q, com_d;
  logic [3:0]  hex_q, hex_d;
  logic        dp_q, dp_d;
  logic        fs_q, fs_d;

  logic        enter_show;
  logic        frame_swap;
  logic [15:0] shifted;
  logic [3:0]  sel_nib;
  logic [3:0]  blank;
  logic        zero3, zero32, zero321;

  // Phase sequencing: SHOW for SCAN_DIV cycles, then GAP for GAP_CYC cycles,
  // advancing the digit index only when GAP hands over to the next SHOW.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q + 1'b1;
    enter_show = 1'b0;
    if (state_q == ST_SHOW) begin
      if (cnt_q == SHOW_LAST) begin
        state_d = ST_GAP;
        cnt_d   = '0;
      end
    end else begin
      if (cnt_q == GAP_LAST) begin
        state_d    = ST_SHOW;
        idx_d      = idx_q + 2'd1;
        cnt_d      = '0;
        enter_show = 1'b1;
      end
    end
  end

  assign frame_swap = enter_show && (idx_q == 2'd3);

  // Pending buffer capture and frame-boundary swap; a load that lands on
  // the swap edge bypasses the buffer and is shown in the frame just starting.
  always_comb begin
    pend_d       = pend_q;
    pend_dp_d    = pend_dp_q;
    pend_valid_d = pend_valid_q;
    shown_d      = shown_q;
    shown_dp_d   = shown_dp_q;
    if (bus.load) begin
      pend_d       = bus.value;
      pend_dp_d    = bus.dp_in;
      pend_valid_d = 1'b1;
    end
    if (frame_swap) begin
      if (bus.load) begin
        shown_d      = bus.value;
        shown_dp_d   = bus.dp_in;
        pend_valid_d = 1'b0;
      end else if (pend_valid_q) begin
        shown_d      = pend_q;
        shown_dp_d   = pend_dp_q;
        pend_valid_d = 1'b0;
      end
    end
  end

  // Leading-zero blanking mask for the value about to be displayed; a digit
  // with its decimal point requested always stays lit.
  always_comb begin
    zero3   = (shown_d[15:12] == 4'h0);
    zero32  = zero3 && (shown_d[11:8] == 4'h0);
    zero321 = zero32 && (shown_d[7:4] == 4'h0);
    blank   = 4'b0000;
    if (bus.blank_lz) begin
      blank[3] = zero3   && !shown_dp_d[3];
      blank[2] = zero32  && !shown_dp_d[2];
      blank[1] = zero321 && !shown_dp_d[1];
    end
  end

  assign shifted = shown_d >> {idx_d, 2'b00};
  assign sel_nib = shifted[3:0];

  // Output next-state: digit outputs are set on SHOW entry and held for the
  // whole SHOW; GAP darkens everything but leaves hex_value unchanged.
  always_comb begin
    com_d = com_q;
    hex_d = hex_q;
    dp_d  = dp_q;
    fs_d  = 1'b0;
    if (state_d == ST_GAP) begin
      com_d = 4'b1111;
      dp_d  = 1'b0;
    end else if (enter_show) begin
      hex_d = sel_nib;
      fs_d  = (idx_d == 2'd0);
      if (blank[idx_d]) begin
        com_d = 4'b1111;
        dp_d  = 1'b0;
      end else begin
        com_d = ~(4'b0001 << idx_d);
        dp_d  = shown_dp_d[idx_d];
      end
    end
  end

  // State, buffers and output registers; reset restarts from the GAP before
  // digit 0 and ignores any load presented in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_GAP;
      idx_q        <= 2'd3;
      cnt_q        <= '0;
      shown_q      <= '0;
      shown_dp_q   <= '0;
      pend_q       <= '0;
      pend_dp_q    <= '0;
      pend_valid_q <= 1'b0;
      com_q        <= 4'b1111;
      hex_q        <= 4'h0;
      dp_q         <= 1'b0;
      fs_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      shown_q      <= shown_d;
      shown_dp_q   <= shown_dp_d;
      pend_q       <= pend_d;
      pend_dp_q    <= pend_dp_d;
      pend_valid_q <= pend_valid_d;
      com_q        <= com_d;
      hex_q        <= hex_d;
      dp_q         <= dp_d;
      fs_q         <= fs_d;
    end
  end

  assign bus.com         = com_q;
  assign bus.hex_value   = hex_q;
  assign bus.dp          = dp_q;
  assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Directed bench for fnd_scan_ctrl with SCAN_DIV=4, GAP_CYC=2 (24-cycle frame).
// Each frame is walked cycle by cycle against hand-written expectations for
// the displayed value, which digits are lit and which decimal points are on.
module tb_fnd_scan_ctrl;

  localparam int SCAN_DIV = 4;
  localparam int GAP_CYC  = 2;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;
  int   curStep;
  int   frameNo;

  fnd_scan_ctrl_if bus ();

  fnd_scan_ctrl #(
    .SCAN_DIV(SCAN_DIV),
    .GAP_CYC (GAP_CYC)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  // Free-running clock, 10 time units per period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("[TB] FAIL %s frame %0d step %0d: observed=%h expected=%h",
             tag, frameNo, curStep, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int s, input int stA, input logic [15:0] vA, input logic [3:0] dA,
                               input int stB, input logic [15:0] vB, input logic [3:0] dB);
    bus.load = 1'b0;
    if (s == stA) begin
      bus.load  = 1'b1;
      bus.value = vA;
      bus.dp_in = dA;
    end else if (s == stB) begin
      bus.load  = 1'b1;
      bus.value = vB;
      bus.dp_in = dB;
    end
  endtask

  // Walk one full frame starting at the first cycle of digit-0 SHOW
  task automatic checkFrame(input logic [15:0] expVal, input logic [3:0] litMask, input logic [3:0] expDp,
                            input int stA, input logic [15:0] vA, input logic [3:0] dA,
                            input int stB, input logic [15:0] vB, input logic [3:0] dB);
    logic [3:0] one;
    logic [3:0] ecom;
    logic [3:0] nib;
    int s;
    one = 4'b0001;
    s   = 0;
    frameNo++;
    for (int d = 0; d < 4; d++) begin
      nib  = 4'(expVal >> (4 * d));
      ecom = litMask[d] ? ~(one << d) : 4'b1111;
      for (int k = 0; k < SCAN_DIV; k++) begin
        curStep = s;
        checkOutput("show_com", {12'h0, bus.com}, {12'h0, ecom});
        checkOutput("show_hex", {12'h0, bus.hex_value}, {12'h0, nib});
        checkOutput("show_dp", {15'h0, bus.dp}, {15'h0, litMask[d] & expDp[d]});
        checkOutput("frame_start", {15'h0, bus.frame_start}, {15'h0, (d == 0 && k == 0)});
        applyStimulus(s, stA, vA, dA, stB, vB, dB);
        s++;
        step();
      end
      for (int g = 0; g < GAP_CYC; g++) begin
        curStep = s;
        checkOutput("gap_com", {12'h0, bus.com}, 16'h000F);
        checkOutput("gap_hex_hold", {12'h0, bus.hex_value}, {12'h0, nib});
        checkOutput("gap_dp", {15'h0, bus.dp}, 16'h0000);
        checkOutput("gap_frame_start", {15'h0, bus.frame_start}, 16'h0000);
        applyStimulus(s, stA, vA, dA, stB, vB, dB);
        s++;
        step();
      end
    end
    bus.load = 1'b0;
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    curStep      = 0;
    frameNo      = 0;
    reset        = 1'b1;
    bus.value    = 16'h0000;
    bus.dp_in    = 4'h0;
    bus.load     = 1'b0;
    bus.blank_lz = 1'b0;

    // Reset values, with a load held during reset that must be ignored
    step();
    bus.load  = 1'b1;
    bus.value = 16'h9999;
    bus.dp_in = 4'hF;
    step();
    checkOutput("rst_com", {12'h0, bus.com}, 16'h000F);
    checkOutput("rst_hex", {12'h0, bus.hex_value}, 16'h0000);
    checkOutput("rst_dp", {15'h0, bus.dp}, 16'h0000);
    checkOutput("rst_frame_start", {15'h0, bus.frame_start}, 16'h0000);
    reset    = 1'b0;
    bus.load = 1'b0;
    step();
    checkOutput("post_rst_gap_com", {12'h0, bus.com}, 16'h000F);
    checkOutput("post_rst_gap_fs", {15'h0, bus.frame_start}, 16'h0000);
    step();

    // Idle frame of zeros, then a mid-frame load shown only in the next frame
    checkFrame(16'h0000, 4'hF, 4'h0, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
    checkFrame(16'h0000, 4'hF, 4'h0, 5, 16'h12AF, 4'b0100, -1, 16'h0, 4'h0);
    // Two loads in one frame: only the last one reaches the display
    checkFrame(16'h12AF, 4'hF, 4'b0100, 3, 16'h1111, 4'h0, 10, 16'h2222, 4'h0);
    // Load on the exact frame-boundary edge goes straight to the display
    checkFrame(16'h2222, 4'hF, 4'h0, 23, 16'hBEEF, 4'h0, -1, 16'h0, 4'h0);
    bus.blank_lz = 1'b1;
    checkFrame(16'hBEEF, 4'hF, 4'h0, 7, 16'h0050, 4'h0, -1, 16'h0, 4'h0);
    // Leading-zero suppression patterns
    checkFrame(16'h0050, 4'b0011, 4'h0, 4, 16'h0000, 4'h0, -1, 16'h0, 4'h0);
    checkFrame(16'h0000, 4'b0001, 4'h0, 4, 16'h0300, 4'h0, -1, 16'h0, 4'h0);
    checkFrame(16'h0300, 4'b0111, 4'h0, 4, 16'h0300, 4'h0, -1, 16'h0, 4'h0);

    // Reset in the middle of digit-2 SHOW aborts the frame
    frameNo++;
    for (int i = 0; i < 13; i++) step();
    curStep = 13;
    checkOutput("mid_show2_com", {12'h0, bus.com}, 16'h000B);
    checkOutput("mid_show2_hex", {12'h0, bus.hex_value}, 16'h0003);
    reset        = 1'b1;
    bus.blank_lz = 1'b0;
    bus.load     = 1'b1;
    bus.value    = 16'hFFFF;
    bus.dp_in    = 4'hF;
    step();
    checkOutput("abort_com", {12'h0, bus.com}, 16'h000F);
    checkOutput("abort_hex", {12'h0, bus.hex_value}, 16'h0000);
    checkOutput("abort_fs", {15'h0, bus.frame_start}, 16'h0000);
    reset    = 1'b0;
    bus.load = 1'b0;
    step();
    checkOutput("abort_gap_com", {12'h0, bus.com}, 16'h000F);
    step();
    checkFrame(16'h0000, 4'hF, 4'h0, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
    checkFrame(16'h0000, 4'hF, 4'h0, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
